cp_stream_scheduler: RTL
========================

Name: cp_stream_scheduler

Overview:
- Affine loop controller that sequences one compiled CGRA copy-stage application.
- Issues read enables to the raw input stream on a programmed 2-D iteration schedule (start delay, initiation interval, extents).
- Carries each sampled word through a fixed-latency pipeline and emits it on the output write stream with a matching valid.
- Sits between the input stream buffer and the application's output write port.

Parameters:
- DATA_W, 16, width of the stream data word.
- CNT_W, 16, width of all configuration fields and loop counters.
- PIPE_LAT, 2, cycles from raw_read_en to out_write_valid; legal range is 1 to 8.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  reset; synchronous, active-high despite the codebase name.
- flush  input  1  synchronous schedule restart.
- start  input  1  one-cycle launch pulse; sampled only in IDLE.
- cfg_start_delay  input  CNT_W  idle cycles between start and the first read.
- cfg_ii  input  CNT_W  cycles between consecutive reads; 0 is treated as 1.
- cfg_ext_x  input  CNT_W  inner extent; 0 is treated as 1.
- cfg_ext_y  input  CNT_W  outer extent; 0 is treated as 1.
- raw_read_en  output  1  read strobe to the input stream.
- raw_read  input  DATA_W  input data; valid in the same cycle raw_read_en is high.
- out_write_valid  output  1  output word valid.
- out_write  output  DATA_W  output data.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset
  - State goes to IDLE; all counters and pipeline valids clear.
  - All outputs are 0, including out_write.
- Configuration latch
  - cfg_* are latched on the accepted start.
  - Later changes to cfg_* are ignored until the next start.
- States: IDLE, DELAY, RUN, DRAIN, DONE.
  - IDLE: start=1 latches config and loads the delay counter with cfg_start_delay, then goes to DELAY. start is ignored in every other state.
  - DELAY: decrements each cycle. When the counter is 0, go to RUN with the ii counter at 0. The first raw_read_en therefore occurs at cycle t+1+cfg_start_delay, where t is the start cycle.
  - RUN: raw_read_en=1 when the ii counter is 0; the ii counter then reloads to ii-1 and decrements to 0.
    - Each read advances x. When x reaches ext_x-1 it wraps to 0 and y increments.
    - The read at (ext_x-1, ext_y-1) is the last read; go to DRAIN the next cycle.
    - Total reads per launch = ext_x*ext_y.
  - DRAIN: no reads. Stay until every pipeline valid is 0, then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. done coincides with the cycle after the last out_write_valid.
- Datapath
  - raw_read is captured when raw_read_en=1.
  - The word travels through PIPE_LAT register stages, each with a valid bit.
  - out_write_valid and out_write are driven from the final stage, exactly PIPE_LAT cycles after the corresponding raw_read_en.
  - out_write holds its last value while out_write_valid=0.
  - Word order is preserved; there is no backpressure.
- flush (priority below reset, above everything else)
  - In DELAY, RUN or DRAIN: clear x, y and the ii counter; clear all pipeline valids (in-flight words are discarded); reload the delay counter from the latched start delay; go to DELAY. The schedule replays from iteration (0,0) with the latched config.
  - In IDLE or DONE: no effect, and done still pulses if already in DONE.
- Arithmetic
  - Counter comparisons use CNT_W-bit unsigned values.
  - The 0-as-1 substitution is applied when config is latched.
  - Loop counters never overflow because they wrap at the extent.
- Reset mid-operation: immediate return to IDLE with all outputs 0, regardless of state.

Optional Feature:
- Macro: CP_SCHED_STALL_EN.
- When defined:
  - Adds input stall (1 bit).
  - While stall=1: the delay and ii counters, x and y hold; raw_read_en is forced to 0; pipeline stages hold contents and valids; out_write_valid is forced to 0.
  - The pipeline resumes on the first cycle stall=0.
  - flush and reset override stall.
- When undefined: the port does not exist and behaviour is as above.

Test Plan:
- Basic schedule, PIPE_LAT=2: ext_x=4, ext_y=2, ii=1, delay=3, start at cycle 0 -> raw_read_en at cycles 4-11; out_write_valid at 6-13 with out_write equal to raw_read from cycles 4-11 in order; done=1 at cycle 14 only; busy 1 from cycles 1-14.
- Initiation interval: ext_x=3, ext_y=1, ii=3, delay=0, start at cycle 0 -> reads at 1, 4, 7; writes at 3, 6, 9; done at 10.
- Zero extents and interval: ext_x=0, ext_y=0, ii=0 -> exactly one read and one write; done the cycle after the write.
- Flush mid-run: basic config, flush=1 at cycle 7 -> no write from the read at cycle 6 (in flight) or any later pre-flush read; reads restart at cycle 8+3=11 for 8 cycles (11-18); done at 21.
- Reset and start-while-busy: start pulsed again at cycle 5 -> ignored, only 8 reads. rst_n=1 at cycle 9 -> every output 0 from cycle 10; a new start then runs the full schedule.
- With CP_SCHED_STALL_EN: stall=1 for cycles 6-8 in the basic config -> reads at 4, 5, 9-14; each write still exactly 2 active cycles after its read; 8 writes total.

Source files
------------

// File: rtl/cp_stream_scheduler.sv
// cp_stream_scheduler: affine 2-D read scheduler for one copy stage. It pushes each sampled word through a PIPE_LAT-deep valid pipeline.
// Latency: PIPE_LAT cycles from raw_read_en to out_write_valid. The first read comes start_delay+1 cycles after the accepted start.
// Backpressure: none in the default build. With CP_SCHED_STALL_EN defined, a stall input freezes the counters and the pipeline.
module cp_stream_scheduler #(
    parameter int DATA_W   = 16,
    parameter int CNT_W    = 16,
    parameter int PIPE_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              start,
`ifdef CP_SCHED_STALL_EN
    input  logic              stall,
`endif
    input  logic [CNT_W-1:0]  cfg_start_delay,
    input  logic [CNT_W-1:0]  cfg_ii,
    input  logic [CNT_W-1:0]  cfg_ext_x,
    input  logic [CNT_W-1:0]  cfg_ext_y,
    output logic              raw_read_en,
    input  logic [DATA_W-1:0] raw_read,
    output logic              out_write_valid,
    output logic [DATA_W-1:0] out_write,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, DELAY, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [CNT_W-1:0] start_delay;
        logic [CNT_W-1:0] ii;
        logic [CNT_W-1:0] ext_x;
        logic [CNT_W-1:0] ext_y;
    } cfg_t;

    localparam logic [CNT_W-1:0]    ONE        = CNT_W'(1);
    localparam logic [PIPE_LAT-1:0] INNER_MASK = {PIPE_LAT{1'b1}} >> 1;

    state_t              state;
    cfg_t                cfg_q;
    logic [CNT_W-1:0]    dly_cnt;
    logic [CNT_W-1:0]    ii_cnt;
    logic [CNT_W-1:0]    x_cnt;
    logic [CNT_W-1:0]    y_cnt;
    logic [PIPE_LAT-1:0] pv;
    logic [DATA_W-1:0]   pd [PIPE_LAT];
    logic [DATA_W-1:0]   last_q;
    logic                hold;
    logic                rd_fire;
    logic                active;

`ifdef CP_SCHED_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    function automatic logic [CNT_W-1:0] nz(input logic [CNT_W-1:0] v);
        return (v == '0) ? ONE : v;
    endfunction

    assign active          = (state == DELAY) || (state == RUN) || (state == DRAIN);
    assign rd_fire         = (state == RUN) && (ii_cnt == '0) && !hold;
    assign raw_read_en     = rd_fire;
    assign out_write_valid = pv[PIPE_LAT-1] && !hold;
    // A stalled final stage may hold a word that has not been emitted yet, so show the last emitted word instead.
    assign out_write       = out_write_valid ? pd[PIPE_LAT-1] : last_q;
    assign busy            = (state != IDLE);
    assign done            = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state   <= IDLE;
            cfg_q   <= '0;
            dly_cnt <= '0;
            ii_cnt  <= '0;
            x_cnt   <= '0;
            y_cnt   <= '0;
            pv      <= '0;
            last_q  <= '0;
            for (int i = 0; i < PIPE_LAT; i++) pd[i] <= '0;
        end else begin
            if (out_write_valid) last_q <= pd[PIPE_LAT-1];

            if (flush && active) begin
                pv <= '0;
            end else if (!hold) begin
                for (int i = PIPE_LAT-1; i > 0; i--) begin
                    pv[i] <= pv[i-1];
                    if (pv[i-1]) pd[i] <= pd[i-1];
                end
                pv[0] <= rd_fire;
                if (rd_fire) pd[0] <= raw_read;
            end

            // A zero start delay skips DELAY, so the first read always lands start_delay+1 cycles later.
            if (flush && active) begin
                x_cnt   <= '0;
                y_cnt   <= '0;
                ii_cnt  <= '0;
                dly_cnt <= cfg_q.start_delay;
                state   <= (cfg_q.start_delay == '0) ? RUN : DELAY;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            cfg_q.start_delay <= cfg_start_delay;
                            cfg_q.ii          <= nz(cfg_ii);
                            cfg_q.ext_x       <= nz(cfg_ext_x);
                            cfg_q.ext_y       <= nz(cfg_ext_y);
                            dly_cnt           <= cfg_start_delay;
                            ii_cnt            <= '0;
                            x_cnt             <= '0;
                            y_cnt             <= '0;
                            state             <= (cfg_start_delay == '0) ? RUN : DELAY;
                        end
                    end
                    DELAY: begin
                        if (!hold) begin
                            if (dly_cnt <= ONE) state <= RUN;
                            else dly_cnt <= dly_cnt - ONE;
                        end
                    end
                    RUN: begin
                        if (!hold) begin
                            if (ii_cnt == '0) begin
                                ii_cnt <= cfg_q.ii - ONE;
                                if (x_cnt == cfg_q.ext_x - ONE) begin
                                    x_cnt <= '0;
                                    if (y_cnt == cfg_q.ext_y - ONE) state <= DRAIN;
                                    else y_cnt <= y_cnt + ONE;
                                end else begin
                                    x_cnt <= x_cnt + ONE;
                                end
                            end else begin
                                ii_cnt <= ii_cnt - ONE;
                            end
                        end
                    end
                    // Leave when only the last stage is occupied: it is emitting now, so DONE follows the final write.
                    DRAIN: begin
                        if (!hold && ((pv & INNER_MASK) == '0)) state <= DONE;
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
